encoder_4to2: RTL and testbench
===============================

ENCODER_4TO2 -- requirements
Module: encoder_4to2

Interface
REQ-001 SHALL have parameter PRIO_HIGH, default 1: 1 = highest set input bit wins on multi-hot input, 0 = lowest set bit wins.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 = registered outputs, 0 = combinational outputs (clk/rst used only by optional error logic).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port y, input, 4 bits: request lines; bit i asserted means code i requested.
REQ-006 SHALL have port a, output, 2 bits: binary index of the selected request line.
REQ-007 SHALL have port vld, output, 1 bit: high when at least one y bit is set.
REQ-008 SHALL have port err, output, 1 bit: multi-hot flag, present only when ENCODER_4TO2_ERR_EN is defined.
REQ-009 SHALL have port err_cnt, output, 8 bits: multi-hot event count, present only when ENCODER_4TO2_ERR_EN is defined.

Function
REQ-010 SHALL encode one-hot y as: 4'b0001->a=2'b00, 4'b0010->2'b01, 4'b0100->2'b10, 4'b1000->2'b11, with vld=1.
REQ-011 SHALL, for multi-hot y, select the highest set index when PRIO_HIGH=1 and the lowest set index when PRIO_HIGH=0, with vld=1.
REQ-012 SHALL, for y=4'b0000, drive a=2'b00 and vld=0.
REQ-013 SHALL, with OUT_REG=1, present a/vld exactly one clk cycle after y is sampled, updating every cycle with no enable.
REQ-014 SHALL, with OUT_REG=0, drive a/vld combinationally from y with zero latency.
REQ-015 SHALL treat X/Z on y as don't-care; no requirement on outputs for non-0/1 inputs.

Reset
REQ-016 SHALL, while rst=1, force registered a=2'b00, vld=0, err=0 and err_cnt=0 immediately, independent of clk.
REQ-017 SHALL resume normal operation on the first rising clk edge after rst deasserts; a reset asserted mid-stream discards the in-flight result.

Configuration
REQ-018 SHALL compile the error feature only when macro ENCODER_4TO2_ERR_EN is defined.
REQ-019 SHALL, with ENCODER_4TO2_ERR_EN defined, assert err with the same latency as a whenever more than one y bit is set.
REQ-020 SHALL, with ENCODER_4TO2_ERR_EN defined, increment err_cnt by one on each clk edge that samples multi-hot y, saturating at 8'hFF.
REQ-021 SHALL, without ENCODER_4TO2_ERR_EN, omit the err and err_cnt ports and their logic entirely; encoding behaviour is unchanged.

Structure
REQ-022 SHALL place the constants IN_W=4, OUT_W=2 and ERR_CNT_W=8 in shared package encoder_4to2_pkg.
REQ-023 SHALL implement the combinational priority encoder in sub-module encoder_4to2_core (inputs y and PRIO_HIGH; outputs a, vld, multi), with encoder_4to2 adding registers and error logic.

Verification
REQ-024 SHALL check one-hot sweep: y=0001, 0010, 0100, 1000, each held 20 ns -> a=00, 01, 10, 11 with vld=1, one cycle later when OUT_REG=1.
REQ-025 SHALL check the all-zero input: y=0000 -> a=00, vld=0, err=0.
REQ-026 SHALL check priority: y=1010 -> a=11 with PRIO_HIGH=1 and a=01 with PRIO_HIGH=0; err=1 when ENCODER_4TO2_ERR_EN is defined.
REQ-027 SHALL check asynchronous reset: rst asserted mid-cycle while y=0100 -> a=00 and vld=0 before the next clk edge; a=10 one edge after release.
REQ-028 SHALL check counter saturation: 300 consecutive cycles of y=0011 with ENCODER_4TO2_ERR_EN defined -> err_cnt=8'hFF and no wrap.
REQ-029 SHALL check combinational mode: OUT_REG=0 and y=0100 -> a=10 within the same timestep.

Source files
------------

// File: rtl/encoder_4to2_pkg.sv
// Shared widths and helpers for the 4-to-2 priority encoder.
package encoder_4to2_pkg;

    localparam int IN_W      = 4;
    localparam int OUT_W     = 2;
    localparam int ERR_CNT_W = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // True when more than one request bit is set (clearing the lowest set bit leaves a residue).
    function automatic logic is_multi_hot(input logic [IN_W-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/encoder_4to2_core.sv
// Purely combinational 4-to-2 priority encoder; PRIO_HIGH selects which end of y wins.
module encoder_4to2_core
    import encoder_4to2_pkg::*;
#(
    parameter int PRIO_HIGH = 1
) (
    input  logic [IN_W-1:0]  y,
    output logic [OUT_W-1:0] a,
    output logic             vld,
    output logic             multi
);

    logic [IN_W-1:0] grant;

    // grant is one-hot (or zero): a bit wins only if no higher-priority bit is set.
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_grant
        if (PRIO_HIGH != 0) begin : g_hi
            if (gi == IN_W - 1) begin : g_top
                assign grant[gi] = y[gi];
            end else begin : g_mid
                assign grant[gi] = y[gi] & ~(|y[IN_W-1:gi+1]);
            end
        end else begin : g_lo
            if (gi == 0) begin : g_bot
                assign grant[gi] = y[gi];
            end else begin : g_mid
                assign grant[gi] = y[gi] & ~(|y[gi-1:0]);
            end
        end
    end

    always_comb begin
        a = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (grant[i]) begin
                a = a | OUT_W'(i);
            end
        end
    end

    assign vld   = |y;
    assign multi = is_multi_hot(y);

endmodule

// File: rtl/encoder_4to2.sv
// 4-to-2 priority encoder with optional output registers (OUT_REG) and an
// optional multi-hot error flag/counter compiled in by ENCODER_4TO2_ERR_EN.
module encoder_4to2
    import encoder_4to2_pkg::*;
#(
    parameter int PRIO_HIGH = 1,
    parameter int OUT_REG   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      y,
    output logic [OUT_W-1:0]     a,
    output logic                 vld
`ifdef ENCODER_4TO2_ERR_EN
    ,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic [OUT_W-1:0] a_comb;
    logic             vld_comb;
    logic             multi_comb;

    encoder_4to2_core #(
        .PRIO_HIGH (PRIO_HIGH)
    ) u_core (
        .y     (y),
        .a     (a_comb),
        .vld   (vld_comb),
        .multi (multi_comb)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic [OUT_W-1:0] a_reg;
        logic             vld_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_reg   <= '0;
                vld_reg <= 1'b0;
            end else begin
                a_reg   <= a_comb;
                vld_reg <= vld_comb;
            end
        end

        assign a   = a_reg;
        assign vld = vld_reg;

`ifdef ENCODER_4TO2_ERR_EN
        logic err_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_reg <= 1'b0;
            end else begin
                err_reg <= multi_comb;
            end
        end

        assign err = err_reg;
`endif
    end else begin : g_out_comb
        assign a   = a_comb;
        assign vld = vld_comb;
`ifdef ENCODER_4TO2_ERR_EN
        assign err = multi_comb;
`endif
    end

`ifdef ENCODER_4TO2_ERR_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    // Counts every sampled multi-hot cycle; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (multi_comb && (err_cnt_reg != ERR_CNT_MAX)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    logic unused_multi;
    assign unused_multi = multi_comb;
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// Self-checking bench: three encoder_4to2 instances (high-priority registered,
// low-priority registered, high-priority combinational) against a behavioural model.
module tb_encoder_4to2;
    import encoder_4to2_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] y   = 4'b0000;

    logic [1:0] a_hi, a_lo, a_cb;
    logic       vld_hi, vld_lo, vld_cb;
`ifdef ENCODER_4TO2_ERR_EN
    logic       err_hi, err_lo, err_cb;
    logic [7:0] cnt_hi, cnt_lo, cnt_cb;
`endif

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    encoder_4to2 #(.PRIO_HIGH(1), .OUT_REG(1)) dut_hi (
        .clk (clk), .rst (rst), .y (y), .a (a_hi), .vld (vld_hi)
`ifdef ENCODER_4TO2_ERR_EN
        , .err (err_hi), .err_cnt (cnt_hi)
`endif
    );

    encoder_4to2 #(.PRIO_HIGH(0), .OUT_REG(1)) dut_lo (
        .clk (clk), .rst (rst), .y (y), .a (a_lo), .vld (vld_lo)
`ifdef ENCODER_4TO2_ERR_EN
        , .err (err_lo), .err_cnt (cnt_lo)
`endif
    );

    encoder_4to2 #(.PRIO_HIGH(1), .OUT_REG(0)) dut_cb (
        .clk (clk), .rst (rst), .y (y), .a (a_cb), .vld (vld_cb)
`ifdef ENCODER_4TO2_ERR_EN
        , .err (err_cb), .err_cnt (cnt_cb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Index of the highest (hi=1) or lowest (hi=0) set bit, by repeated halving.
    function automatic int model_idx(input int v, input bit hi);
        int t;
        int idx;
        t = v;
        idx = 0;
        if (v == 0) return 0;
        if (hi) begin
            while (t > 1) begin
                t = t / 2;
                idx++;
            end
        end else begin
            while (t % 2 == 0) begin
                t = t / 2;
                idx++;
            end
        end
        return idx;
    endfunction

    function automatic int model_multi(input int v);
        return ($countones(v[3:0]) > 1) ? 1 : 0;
    endfunction

    // Called on a negedge: drive v, check combinational instance, then check
    // registered instances on the following negedge (one clk edge later).
    task automatic step(input logic [3:0] v);
        int iv;
        iv = int'(v);
        y = v;
        #1;
        check("comb_a",   32'(a_cb),   32'(model_idx(iv, 1'b1)));
        check("comb_vld", 32'(vld_cb), 32'(iv != 0));
`ifdef ENCODER_4TO2_ERR_EN
        check("comb_err", 32'(err_cb), 32'(model_multi(iv)));
`endif
        @(posedge clk);
        if (!rst && model_multi(iv) == 1 && model_cnt < 255) model_cnt++;
        @(negedge clk);
        check("hi_a",   32'(a_hi),   32'(model_idx(iv, 1'b1)));
        check("hi_vld", 32'(vld_hi), 32'(iv != 0));
        check("lo_a",   32'(a_lo),   32'(model_idx(iv, 1'b0)));
        check("lo_vld", 32'(vld_lo), 32'(iv != 0));
`ifdef ENCODER_4TO2_ERR_EN
        check("hi_err", 32'(err_hi), 32'(model_multi(iv)));
        check("lo_err", 32'(err_lo), 32'(model_multi(iv)));
        check("hi_cnt", 32'(cnt_hi), 32'(model_cnt));
        check("lo_cnt", 32'(cnt_lo), 32'(model_cnt));
        check("cb_cnt", 32'(cnt_cb), 32'(model_cnt));
`endif
        $display("txn y=%b a_hi=%0d a_lo=%0d a_cb=%0d vld=%0b", v, a_hi, a_lo, a_cb, vld_hi);
    endtask

    initial begin
        // Reset held with all requests set: outputs must stay cleared.
        rst = 1'b1;
        y   = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_hi_a",   32'(a_hi),   32'd0);
        check("rst_hi_vld", 32'(vld_hi), 32'd0);
        check("rst_lo_a",   32'(a_lo),   32'd0);
        check("rst_lo_vld", 32'(vld_lo), 32'd0);
`ifdef ENCODER_4TO2_ERR_EN
        check("rst_hi_err", 32'(err_hi), 32'd0);
        check("rst_hi_cnt", 32'(cnt_hi), 32'd0);
        check("rst_cb_cnt", 32'(cnt_cb), 32'd0);
`endif
        model_cnt = 0;
        rst = 1'b0;

        // One-hot sweep, each value held two cycles (20 ns).
        for (int i = 0; i < 4; i++) begin
            step(4'(1 << i));
            step(4'(1 << i));
        end

        step(4'b0000);
        step(4'b1010);

        for (int n = 0; n < 200; n++) begin
            step(4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-cycle while y=0100.
        step(4'b0100);
        #2 rst = 1'b1;
        #1;
        model_cnt = 0;
        check("arst_hi_a",   32'(a_hi),   32'd0);
        check("arst_hi_vld", 32'(vld_hi), 32'd0);
        check("arst_lo_a",   32'(a_lo),   32'd0);
        check("arst_cb_a",   32'(a_cb),   32'd2);
`ifdef ENCODER_4TO2_ERR_EN
        check("arst_hi_cnt", 32'(cnt_hi), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(4'b0100);

        // Saturation: 300 consecutive multi-hot cycles.
        for (int n = 0; n < 300; n++) begin
            step(4'b0011);
        end
`ifdef ENCODER_4TO2_ERR_EN
        check("sat_cnt", 32'(cnt_hi), 32'hFF);
        check("sat_err", 32'(err_hi), 32'd1);
`endif
        step(4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
